// File: rtl/i2c_gpio_target_pkg.sv
// Shared types and constants for the I2C GPIO expander target.
package i2c_gpio_target_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StRegPtr,
      StPtrAck,
      StWrData,
      StWrAck,
      StRdData,
      StRdAck,
      StIgnore
   } i2c_state_e;

   // Register map (pointer values)
   localparam logic [2:0] REG_IN0  = 3'd0;
   localparam logic [2:0] REG_IN1  = 3'd1;
   localparam logic [2:0] REG_OUT0 = 3'd2;
   localparam logic [2:0] REG_OUT1 = 3'd3;
   localparam logic [2:0] REG_POL0 = 3'd4;
   localparam logic [2:0] REG_POL1 = 3'd5;
   localparam logic [2:0] REG_CFG0 = 3'd6;
   localparam logic [2:0] REG_CFG1 = 3'd7;

   // Reset values
   localparam logic [7:0] OUT_RST = 8'hFF;
   localparam logic [7:0] POL_RST = 8'h00;
   localparam logic [7:0] CFG_RST = 8'hFF;

   // Pointer auto-advance stays within a register pair (0<->1, 2<->3, ...)
   function automatic logic [2:0] pair_next(input logic [2:0] ptr);
      return {ptr[2:1], ~ptr[0]};
   endfunction

endpackage

// File: rtl/i2c_gpio_target_bus_sync.sv
// SCL/SDA synchronizers with edge, START and STOP detection.
module i2c_gpio_target_bus_sync (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_hist_q, sda_hist_q;

   // Two-flop synchronizers plus one history flop; idle bus reads as high
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_i};
         sda_sync_q <= {sda_sync_q[0], sda_i};
         scl_hist_q <= scl_sync_q[1];
         sda_hist_q <= sda_sync_q[1];
      end
   end

   assign sda_o      = sda_sync_q[1];
   assign scl_rise_o = scl_sync_q[1] & ~scl_hist_q;
   assign scl_fall_o = ~scl_sync_q[1] & scl_hist_q;
   // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP
   assign start_o    = scl_sync_q[1] & scl_hist_q & sda_hist_q & ~sda_sync_q[1];
   assign stop_o     = scl_sync_q[1] & scl_hist_q & ~sda_hist_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_gpio_target.sv
// I2C target emulating a 16-bit PCA9535-style GPIO expander.
module i2c_gpio_target
   import i2c_gpio_target_pkg::*;
#(
   parameter logic [6:0] I2C_ADR    = 7'h20,
   parameter bit         INT_ENABLE = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_scl,
   input  logic        i_sda,
   output logic        o_sda_oe,
   input  logic [15:0] i_gpio,
   output logic [15:0] o_gpio,
   output logic [15:0] o_gpio_oe,
   output logic        o_int_n,
   output logic        o_busy
);

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   i2c_gpio_target_bus_sync u_bus_sync (
      .clk_i      (i_clk),
      .rst_ni     (i_reset_n),
      .scl_i      (i_scl),
      .sda_i      (i_sda),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start_det),
      .stop_o     (stop_det)
   );

   i2c_state_e  state_q;
   logic [7:0]  shift_q;
   logic [6:0]  tx_q;      // remaining read bits after the one on the bus
   logic [3:0]  cnt_q;
   logic [2:0]  ptr_q;
   logic        rw_q;
   logic        mack_q;    // master ACK bit, 0 = ACK
   logic        sda_oe_q;
   logic        busy_q;
   logic [7:0]  out_q [2];
   logic [7:0]  pol_q [2];
   logic [7:0]  cfg_q [2];
   logic [15:0] gpio_meta_q, gpio_s_q;
   logic [15:0] int_lat_q, int_lat_d;
   logic        int_n_q;

   logic [15:0] in_reg;
   logic [2:0]  rd_ptr;
   logic [7:0]  rd_byte;
   logic        rd_load;

   // Pin input synchronizer
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         gpio_meta_q <= '0;
         gpio_s_q    <= '0;
      end else begin
         gpio_meta_q <= i_gpio;
         gpio_s_q    <= gpio_meta_q;
      end
   end

   // Read-data mux; an ACKed read fetches the other register of the pair
   always_comb begin
      in_reg  = gpio_s_q ^ {pol_q[1], pol_q[0]};
      rd_ptr  = (state_q == StRdAck) ? pair_next(ptr_q) : ptr_q;
      rd_byte = 8'h00;
      unique case ({rd_ptr[2:1], 1'b0})
         REG_IN0:  rd_byte = rd_ptr[0] ? in_reg[15:8] : in_reg[7:0];
         REG_OUT0: rd_byte = out_q[rd_ptr[0]];
         REG_POL0: rd_byte = pol_q[rd_ptr[0]];
         REG_CFG0: rd_byte = cfg_q[rd_ptr[0]];
         default:  rd_byte = 8'h00;
      endcase
      // Same condition under which the FSM loads tx_q below
      rd_load = scl_fall && !start_det && !stop_det &&
                ((state_q == StAddrAck && rw_q) || (state_q == StRdAck && !mack_q));
   end

   // Protocol FSM with shift register, bit counter, pointer and register file
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q  <= StIdle;
         shift_q  <= '0;
         tx_q     <= '0;
         cnt_q    <= '0;
         ptr_q    <= REG_IN0;
         rw_q     <= 1'b0;
         mack_q   <= 1'b1;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         out_q[0] <= OUT_RST;
         out_q[1] <= OUT_RST;
         pol_q[0] <= POL_RST;
         pol_q[1] <= POL_RST;
         cfg_q[0] <= CFG_RST;
         cfg_q[1] <= CFG_RST;
      end else if (stop_det) begin
         state_q  <= StIdle;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
      end else if (start_det) begin
         // Also covers repeated START; pointer is retained
         state_q  <= StAddr;
         cnt_q    <= '0;
         sda_oe_q <= 1'b0;
      end else begin
         unique case (state_q)
            StAddr: begin
               if (scl_rise) begin
                  shift_q <= {shift_q[6:0], sda_s};
                  cnt_q   <= cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  if (shift_q[7:1] == I2C_ADR) begin
                     state_q  <= StAddrAck;
                     sda_oe_q <= 1'b1;
                     busy_q   <= 1'b1;
                     rw_q     <= shift_q[0];
                  end else begin
                     state_q <= StIgnore;
                     busy_q  <= 1'b0;
                  end
               end
            end
            StAddrAck: begin
               if (scl_fall) begin
                  cnt_q <= '0;
                  if (rw_q) begin
                     state_q  <= StRdData;
                     tx_q     <= rd_byte[6:0];
                     sda_oe_q <= ~rd_byte[7];
                  end else begin
                     state_q  <= StRegPtr;
                     sda_oe_q <= 1'b0;
                  end
               end
            end
            StRegPtr: begin
               if (scl_rise) begin
                  shift_q <= {shift_q[6:0], sda_s};
                  cnt_q   <= cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  state_q  <= StPtrAck;
                  sda_oe_q <= 1'b1;
                  ptr_q    <= shift_q[2:0];
               end
            end
            StPtrAck, StWrAck: begin
               if (scl_fall) begin
                  state_q  <= StWrData;
                  sda_oe_q <= 1'b0;
                  cnt_q    <= '0;
               end
            end
            StWrData: begin
               if (scl_rise) begin
                  shift_q <= {shift_q[6:0], sda_s};
                  cnt_q   <= cnt_q + 4'd1;
               end else if (scl_fall && cnt_q == 4'd8) begin
                  state_q  <= StWrAck;
                  sda_oe_q <= 1'b1;
                  ptr_q    <= pair_next(ptr_q);
                  unique case ({ptr_q[2:1], 1'b0})
                     REG_OUT0: out_q[ptr_q[0]] <= shift_q;
                     REG_POL0: pol_q[ptr_q[0]] <= shift_q;
                     REG_CFG0: cfg_q[ptr_q[0]] <= shift_q;
                     default: ;  // input registers are read-only; byte still ACKed
                  endcase
               end
            end
            StRdData: begin
               if (scl_rise) begin
                  cnt_q <= cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     state_q  <= StRdAck;
                     sda_oe_q <= 1'b0;
                  end else begin
                     sda_oe_q <= ~tx_q[6];
                     tx_q     <= {tx_q[5:0], 1'b0};
                  end
               end
            end
            StRdAck: begin
               if (scl_rise) begin
                  mack_q <= sda_s;
               end else if (scl_fall) begin
                  if (!mack_q) begin
                     state_q  <= StRdData;
                     ptr_q    <= rd_ptr;
                     tx_q     <= rd_byte[6:0];
                     sda_oe_q <= ~rd_byte[7];
                     cnt_q    <= '0;
                  end else begin
                     state_q  <= StIgnore;
                     sda_oe_q <= 1'b0;
                  end
               end
            end
            default: ;  // StIdle, StIgnore: wait for START/STOP
         endcase
      end
   end

   // Interrupt reference updates when an input port is loaded for reading
   always_comb begin
      int_lat_d = int_lat_q;
      if (rd_load && rd_ptr == REG_IN0) int_lat_d[7:0]  = gpio_s_q[7:0];
      if (rd_load && rd_ptr == REG_IN1) int_lat_d[15:8] = gpio_s_q[15:8];
   end

   // Interrupt: any synced input differing from its last-read value
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         int_lat_q <= '0;
         int_n_q   <= 1'b1;
      end else begin
         int_lat_q <= int_lat_d;
         int_n_q   <= ~(INT_ENABLE && (gpio_s_q != int_lat_d));
      end
   end

   assign o_sda_oe  = sda_oe_q;
   assign o_gpio    = {out_q[1], out_q[0]};
   assign o_gpio_oe = ~{cfg_q[1], cfg_q[0]};
   assign o_int_n   = int_n_q;
   assign o_busy    = busy_q;

endmodule

// File: tb/tb_i2c_gpio_target.sv
// Directed bench: bit-banged I2C master against the GPIO expander target.
module tb_i2c_gpio_target;

   localparam int Q = 10;  // SCL quarter period in clocks

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl_m = 1'b1;
   logic        sda_m = 1'b1;
   logic        sda_bus;
   logic        sda_oe;
   logic [15:0] gpio_in = 16'h0000;
   logic [15:0] gpio_out, gpio_oe;
   logic        int_n, busy;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   // Open-drain wired-AND of master and target
   assign sda_bus = sda_m & ~sda_oe;

   always #10 clk = ~clk;

   i2c_gpio_target dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_scl     (scl_m),
      .i_sda     (sda_bus),
      .o_sda_oe  (sda_oe),
      .i_gpio    (gpio_in),
      .o_gpio    (gpio_out),
      .o_gpio_oe (gpio_oe),
      .o_int_n   (int_n),
      .o_busy    (busy)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      sda_m = 1'b1; wait_clk(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_clk(Q);
      scl_m = 1'b1; wait_clk(2 * Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; wait_clk(Q);
      scl_m = 1'b1; wait_clk(Q);
      b = sda_bus;  wait_clk(Q);
      scl_m = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] data, output logic ack);
      for (int i = 7; i >= 0; i--) write_bit(data[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] data, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         data[i] = b;
      end
      write_bit(ack);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack;
      logic [7:0] rd;
      logic       seen;

      wait_clk(5);
      check_eq("rst_sda_oe", sda_oe, 0);
      check_eq("rst_gpio", gpio_out, 16'hFFFF);
      check_eq("rst_gpio_oe", gpio_oe, 16'h0000);
      check_eq("rst_int_n", int_n, 1);
      check_eq("rst_busy", busy, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // Write output port pair
      i2c_start();
      write_byte(8'h40, ack); check_eq("wr_addr_ack", ack, 0);
      check_eq("busy_addressed", busy, 1);
      write_byte(8'h02, ack); check_eq("wr_ptr_ack", ack, 0);
      write_byte(8'hA5, ack); check_eq("wr_d0_ack", ack, 0);
      write_byte(8'h3C, ack); check_eq("wr_d1_ack", ack, 0);
      i2c_stop();
      check_eq("gpio_out", gpio_out, 16'h3CA5);
      check_eq("busy_after_stop", busy, 0);

      // Configure port 0 as outputs
      i2c_start();
      write_byte(8'h40, ack); check_eq("cfg_addr_ack", ack, 0);
      write_byte(8'h06, ack); check_eq("cfg_ptr_ack", ack, 0);
      write_byte(8'h00, ack); check_eq("cfg_d_ack", ack, 0);
      i2c_stop();
      check_eq("gpio_oe", gpio_oe, 16'h00FF);

      // Read input ports, pointer 0, via repeated START
      gpio_in = 16'h1234;
      wait_clk(5);
      check_eq("int_on_input", int_n, 0);
      i2c_start();
      write_byte(8'h40, ack); check_eq("rd_waddr_ack", ack, 0);
      write_byte(8'h00, ack); check_eq("rd_ptr_ack", ack, 0);
      i2c_start();
      write_byte(8'h41, ack); check_eq("rd_raddr_ack", ack, 0);
      read_byte(rd, 1'b0); check_eq("rd_in0", rd, 8'h34);
      read_byte(rd, 1'b1); check_eq("rd_in1", rd, 8'h12);
      i2c_stop();
      check_eq("int_cleared", int_n, 1);

      // Address mismatch: nothing ACKed, nothing written
      i2c_start();
      write_byte(8'h42, ack); check_eq("bad_addr_nack", ack, 1);
      check_eq("bad_addr_busy", busy, 0);
      write_byte(8'h02, ack); check_eq("bad_ptr_nack", ack, 1);
      write_byte(8'h00, ack);
      i2c_stop();
      check_eq("bad_addr_gpio", gpio_out, 16'h3CA5);

      // Polarity inversion pair, then read inputs through it
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h04, ack);
      write_byte(8'h0F, ack); check_eq("pol0_ack", ack, 0);
      write_byte(8'hF0, ack); check_eq("pol1_ack", ack, 0);
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h00, ack);
      i2c_start();
      write_byte(8'h41, ack);
      read_byte(rd, 1'b0); check_eq("pol_in0", rd, 8'h3B);
      read_byte(rd, 1'b1); check_eq("pol_in1", rd, 8'hE2);
      i2c_stop();

      // Pointer 7 then read: reg 7 then reg 6
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h07, ack);
      i2c_start();
      write_byte(8'h41, ack);
      read_byte(rd, 1'b0); check_eq("rd_reg7", rd, 8'hFF);
      read_byte(rd, 1'b1); check_eq("rd_reg6", rd, 8'h00);
      i2c_stop();

      // Write to input reg 0: ACKed, discarded, pointer moves to 1
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h00, ack);
      write_byte(8'h55, ack); check_eq("wr_in0_ack", ack, 0);
      i2c_start();
      write_byte(8'h41, ack);
      read_byte(rd, 1'b1); check_eq("rd_after_ro_wr", rd, 8'hE2);
      i2c_stop();
      check_eq("ro_wr_gpio", gpio_out, 16'h3CA5);

      // Interrupt on single input change, cleared by reading port 0
      check_eq("int_idle", int_n, 1);
      gpio_in = 16'h123C;
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         wait_clk(1);
         if (!int_n) seen = 1'b1;
      end
      check_eq("int_assert", seen, 1);
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h00, ack);
      i2c_start();
      write_byte(8'h41, ack);
      read_byte(rd, 1'b1); check_eq("int_rd_in0", rd, 8'h33);
      i2c_stop();
      check_eq("int_deassert", int_n, 1);

      // Reset while target drives a 0 during a read
      i2c_start();
      write_byte(8'h40, ack);
      write_byte(8'h06, ack);
      i2c_start();
      write_byte(8'h41, ack); check_eq("mid_rd_ack", ack, 0);
      check_eq("mid_rd_drive", sda_oe, 1);
      rst_n = 1'b0;
      #1;
      check_eq("async_sda_oe", sda_oe, 0);
      check_eq("async_gpio", gpio_out, 16'hFFFF);
      check_eq("async_gpio_oe", gpio_oe, 16'h0000);
      check_eq("async_busy", busy, 0);
      check_eq("async_int_n", int_n, 1);
      wait_clk(3);
      rst_n = 1'b1;
      wait_clk(3);
      i2c_stop();

      // After reset: pointer 0, polarity cleared
      i2c_start();
      write_byte(8'h41, ack); check_eq("post_rst_ack", ack, 0);
      read_byte(rd, 1'b1); check_eq("post_rst_in0", rd, 8'h3C);
      i2c_stop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
